// File: rtl/sha_round_ctrl.sv
// Sequencer for the shared SHA-256 round datapath: IDLE -> INIT -> ROUND x ROUNDS -> FINAL -> DONE.
// Optional macro SHA_CTRL_PENDING_EN adds a one-deep queue for a request that arrives while busy.
module sha_round_ctrl #(
   parameter int unsigned ROUNDS = 64,
   parameter int unsigned IDX_W  = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_sha_in,
   input  logic             abort,
   output logic             ready,
   output logic             pipe_stall,
   output logic             init_load,
   output logic             round_en,
   output logic [IDX_W-1:0] round_idx,
   output logic             w_sel,
   output logic [1:0]       sel_mux_res_sha,
   output logic             plus1,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pend_q;
   logic             rerun;

`ifdef SHA_CTRL_PENDING_EN
   logic pend_d;

   always_comb begin
      pend_d = pend_q;
      if (abort || state_q == S_DONE) begin
         pend_d = 1'b0;
      end else if (start_sha_in && state_q != S_IDLE) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // A request landing in DONE itself is consumed directly rather than queued.
   assign rerun = pend_q | start_sha_in;
`else
   assign pend_q = 1'b0;
   assign rerun  = pend_q;
`endif

   // NOTE: every combinational output gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = '0;
      case (state_q)
         S_IDLE:  if (start_sha_in) state_d = S_INIT;
         S_INIT:  state_d = S_ROUND;
         S_ROUND: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_FINAL;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_FINAL: state_d = S_DONE;
         S_DONE:  state_d = rerun ? S_INIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Flush overrides everything, including a simultaneous start.
      if (abort) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end
   end

   // NOTE: the reset is asynchronous so a mid-operation reset drops the stall in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Moore decodes only; the counter is already zero outside ROUND.
   always_comb begin
      ready           = 1'b0;
      pipe_stall      = 1'b0;
      init_load       = 1'b0;
      round_en        = 1'b0;
      w_sel           = 1'b0;
      sel_mux_res_sha = 2'b00;
      done            = 1'b0;
      case (state_q)
         S_IDLE:  ready = 1'b1;
         S_INIT: begin
            pipe_stall = 1'b1;
            init_load  = 1'b1;
         end
         S_ROUND: begin
            pipe_stall      = 1'b1;
            round_en        = 1'b1;
            sel_mux_res_sha = 2'b01;
            w_sel           = (32'(idx_q) >= 32'd16);
         end
         S_FINAL: begin
            pipe_stall      = 1'b1;
            sel_mux_res_sha = 2'b10;
         end
         S_DONE: begin
            done            = 1'b1;
            sel_mux_res_sha = 2'b11;
         end
         default: ready = 1'b0;
      endcase
   end

   assign round_idx = idx_q;
   // Final add is a plain modulo-2^32 sum, so the carry-in is never used.
   assign plus1     = 1'b0;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Bench for sha_round_ctrl: two instances (ROUNDS=64 and ROUNDS=2) driven from shared inputs,
// directed vector table plus randomized traffic against a sequence-position reference model.
module tb_sha_round_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_sha_in;
   logic       abort;

   logic       ready_a, stall_a, init_a, round_a, wsel_a, plus1_a, done_a;
   logic [5:0] idx_a;
   logic [1:0] sel_a;
   logic       ready_b, stall_b, init_b, round_b, wsel_b, plus1_b, done_b;
   logic [0:0] idx_b;
   logic [1:0] sel_b;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   always #5 clk = ~clk;

   sha_round_ctrl dut_a (
      .clk(clk), .reset(reset), .start_sha_in(start_sha_in), .abort(abort),
      .ready(ready_a), .pipe_stall(stall_a), .init_load(init_a), .round_en(round_a),
      .round_idx(idx_a), .w_sel(wsel_a), .sel_mux_res_sha(sel_a), .plus1(plus1_a),
      .done(done_a)
   );

   sha_round_ctrl #(.ROUNDS(2), .IDX_W(1)) dut_b (
      .clk(clk), .reset(reset), .start_sha_in(start_sha_in), .abort(abort),
      .ready(ready_b), .pipe_stall(stall_b), .init_load(init_b), .round_en(round_b),
      .round_idx(idx_b), .w_sel(wsel_b), .sel_mux_res_sha(sel_b), .plus1(plus1_b),
      .done(done_b)
   );

   function automatic logic [31:0] pack(input logic rdy, input logic stl, input logic ini,
                                        input logic rnd, input logic ws, input logic [1:0] sl,
                                        input logic p1, input logic dn, input int idx);
      logic [7:0] i8;
      i8 = idx[7:0];
      return {15'd0, rdy, stl, ini, rnd, ws, sl, p1, dn, i8};
   endfunction

   function automatic logic [31:0] act_a();
      return pack(ready_a, stall_a, init_a, round_a, wsel_a, sel_a, plus1_a, done_a, int'(idx_a));
   endfunction

   function automatic logic [31:0] act_b();
      return pack(ready_b, stall_b, init_b, round_b, wsel_b, sel_b, plus1_b, done_b, int'(idx_b));
   endfunction

   // Hand-written expected output sets for each phase of an operation.
   function automatic logic [31:0] e_idle();
      return pack(1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
   endfunction
   function automatic logic [31:0] e_init();
      return pack(0, 1, 1, 0, 0, 2'd0, 0, 0, 0);
   endfunction
   function automatic logic [31:0] e_round(input int i);
      return pack(0, 1, 0, 1, (i >= 16), 2'd1, 0, 0, i);
   endfunction
   function automatic logic [31:0] e_final();
      return pack(0, 1, 0, 0, 0, 2'd2, 0, 0, 0);
   endfunction
   function automatic logic [31:0] e_done();
      return pack(0, 0, 0, 0, 0, 2'd3, 0, 1, 0);
   endfunction

   // Reference model: an operation is a position t along a fixed timeline
   // (0 = init, 1..R = rounds, R+1 = final add, R+2 = completion).
   bit m_act[2];
   int m_t[2];
   bit m_pend[2];
   int m_r[2];

   task automatic mdl_reset();
      for (int k = 0; k < 2; k++) begin
         m_act[k]  = 1'b0;
         m_t[k]    = 0;
         m_pend[k] = 1'b0;
      end
   endtask

   task automatic mdl_step(input int k, input logic s, input logic a);
      if (!m_act[k]) begin
         if (s && !a) begin
            m_act[k] = 1'b1;
            m_t[k]   = 0;
         end
      end else if (a) begin
         m_act[k]  = 1'b0;
         m_pend[k] = 1'b0;
      end else begin
`ifdef SHA_CTRL_PENDING_EN
         if (s) m_pend[k] = 1'b1;
`endif
         if (m_t[k] == m_r[k] + 2) begin
            if (m_pend[k]) begin
               m_t[k]    = 0;
               m_pend[k] = 1'b0;
            end else begin
               m_act[k] = 1'b0;
            end
         end else begin
            m_t[k]++;
         end
      end
   endtask

   function automatic logic [31:0] mdl_expect(input int k);
      int       t;
      int       r;
      logic     in_rounds;
      logic [1:0] sl;
      t = m_t[k];
      r = m_r[k];
      if (!m_act[k]) return pack(1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
      in_rounds = (t >= 1) && (t <= r);
      if (t == 0)           sl = 2'd0;
      else if (in_rounds)   sl = 2'd1;
      else if (t == r + 1)  sl = 2'd2;
      else                  sl = 2'd3;
      return pack(0, (t <= r + 1), (t == 0), in_rounds, in_rounds && (t - 1 >= 16), sl,
                  0, (t == r + 2), in_rounds ? t - 1 : 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic step(input logic s, input logic a);
      start_sha_in = s;
      abort        = a;
      @(posedge clk);
      cyc++;
      mdl_step(0, s, a);
      mdl_step(1, s, a);
      #1;
      check("model_a", act_a(), mdl_expect(0));
      check("model_b", act_b(), mdl_expect(1));
      start_sha_in = 1'b0;
      abort        = 1'b0;
   endtask

   typedef struct {
      logic        start;
      logic        abrt;
      int          skip;
      logic [31:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic a, input int skip, input logic [31:0] e);
      vec_t v;
      v.start = s;
      v.abrt  = a;
      v.skip  = skip;
      v.exp   = e;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      m_r[0] = 64;
      m_r[1] = 2;
      reset        = 1'b0;
      start_sha_in = 1'b0;
      abort        = 1'b0;
      mdl_reset();

      // Single run, ROUNDS=64: INIT at 1, rounds 2..65, w_sel from 18, FINAL 66, DONE 67, IDLE 68.
      vecs.push_back(mk(1, 0, 0,  e_init()));
      vecs.push_back(mk(0, 0, 0,  e_round(0)));
      vecs.push_back(mk(0, 0, 15, e_round(16)));
      vecs.push_back(mk(0, 0, 46, e_round(63)));
      vecs.push_back(mk(0, 0, 0,  e_final()));
      vecs.push_back(mk(0, 0, 0,  e_done()));
      vecs.push_back(mk(0, 0, 0,  e_idle()));
      // Abort at round 28, then a fresh full run.
      vecs.push_back(mk(1, 0, 0,  e_init()));
      vecs.push_back(mk(0, 0, 28, e_round(28)));
      vecs.push_back(mk(0, 1, 0,  e_idle()));
      vecs.push_back(mk(0, 0, 2,  e_idle()));
      vecs.push_back(mk(1, 0, 0,  e_init()));
      vecs.push_back(mk(0, 0, 65, e_done()));
      vecs.push_back(mk(0, 0, 0,  e_idle()));
      // Start and abort together in IDLE.
      vecs.push_back(mk(1, 1, 0,  e_idle()));
      vecs.push_back(mk(0, 0, 0,  e_idle()));
      // Second request at cycle 40 during ROUND.
      vecs.push_back(mk(1, 0, 0,  e_init()));
      vecs.push_back(mk(0, 0, 37, e_round(37)));
      vecs.push_back(mk(1, 0, 0,  e_round(38)));
      vecs.push_back(mk(0, 0, 26, e_done()));
`ifdef SHA_CTRL_PENDING_EN
      vecs.push_back(mk(0, 0, 0,  e_init()));
      vecs.push_back(mk(0, 0, 65, e_done()));
`else
      vecs.push_back(mk(0, 0, 0,  e_idle()));
      vecs.push_back(mk(0, 0, 65, e_idle()));
`endif
      vecs.push_back(mk(0, 0, 0,  e_idle()));

      repeat (3) @(posedge clk);
      #1;
      check("reset_a", act_a(), e_idle());
      check("reset_b", act_b(), e_idle());
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].start, vecs[i].abrt);
         for (int j = 0; j < vecs[i].skip; j++) step(1'b0, 1'b0);
         check($sformatf("vec%0d", i), act_a(), vecs[i].exp);
      end

      // Asynchronous reset mid-ROUND at cycle 20 takes effect before the next edge.
      step(1'b1, 1'b0);
      for (int j = 0; j < 19; j++) step(1'b0, 1'b0);
      check("pre_reset_a", act_a(), e_round(18));
      #2;
      reset = 1'b0;
      #1;
      mdl_reset();
      check("async_reset_a", act_a(), e_idle());
      check("async_reset_b", act_b(), e_idle());
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
      check("post_reset_a", act_a(), e_idle());

      // ROUNDS=2, IDX_W=1: indices 0,1 with w_sel low, done at cycle 5.
      step(1'b1, 1'b0);
      check("b_init", act_b(), pack(0, 1, 1, 0, 0, 2'd0, 0, 0, 0));
      step(1'b0, 1'b0);
      check("b_round0", act_b(), pack(0, 1, 0, 1, 0, 2'd1, 0, 0, 0));
      step(1'b0, 1'b0);
      check("b_round1", act_b(), pack(0, 1, 0, 1, 0, 2'd1, 0, 0, 1));
      step(1'b0, 1'b0);
      check("b_final", act_b(), pack(0, 1, 0, 0, 0, 2'd2, 0, 0, 0));
      step(1'b0, 1'b0);
      check("b_done", act_b(), pack(0, 0, 0, 0, 0, 2'd3, 0, 1, 0));
      step(1'b0, 1'b0);
      check("b_idle", act_b(), pack(1, 0, 0, 0, 0, 2'd0, 0, 0, 0));

      // Randomized traffic, checked every cycle against the model.
      for (int n = 0; n < 4000; n++) begin
         step(($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
